// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its surroundings.
// The master side is the supervisor itself.
interface pll_lock_supervisor_if;
  logic       locked;
  logic       retry_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lol_count;

  modport master (
    input  locked, retry_req,
    output pll_rst, sys_rst, fault, state, lol_count
  );

  modport slave (
    output locked, retry_req,
    input  pll_rst, sys_rst, fault, state, lol_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// releases the system reset, and retries or faults when lock never comes.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES = 10,
  parameter int LOCK_TIMEOUT     = 50000,
  parameter int LOCK_STABLE      = 1024,
  parameter int MAX_RETRIES      = 3
) (
  input logic                   refclk,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);
  localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int CW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } st_e;

  st_e         st;
  logic [1:0]  sync_q;
  logic        locked_s;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] stab_cnt;
  logic [CW-1:0] retry_cnt;
  logic        pll_rst_q, sys_rst_q, fault_q;
  logic [7:0]  lol_q;

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      st        <= PLL_RESET;
      sync_q    <= '0;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      stab_cnt  <= '0;
      retry_cnt <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fault_q   <= 1'b0;
      lol_q     <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.locked};
      case (st)
        PLL_RESET: begin
          if (rst_cnt == RW'(RST_PULSE_CYCLES - 1)) begin
            st        <= WAIT_LOCK;
            rst_cnt   <= '0;
            to_cnt    <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (locked_s) begin
            st       <= STABILIZE;
            stab_cnt <= '0;
          end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
            to_cnt    <= '0;
            retry_cnt <= retry_cnt + CW'(1);
            pll_rst_q <= 1'b1;
            if (retry_cnt == CW'(MAX_RETRIES - 1)) begin
              st      <= FAULT;
              fault_q <= 1'b1;
            end else begin
              st      <= PLL_RESET;
              rst_cnt <= '0;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            st     <= WAIT_LOCK;
            to_cnt <= '0;
          end else if (stab_cnt == SW'(LOCK_STABLE - 1)) begin
            st        <= RUN;
            sys_rst_q <= 1'b0;
            retry_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            st        <= PLL_RESET;
            rst_cnt   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            if (lol_q != 8'hFF) lol_q <= lol_q + 8'd1;
          end
        end
        FAULT: begin
          if (bus.retry_req) begin
            st        <= PLL_RESET;
            retry_cnt <= '0;
            rst_cnt   <= '0;
            fault_q   <= 1'b0;
          end
        end
        default: begin
          st        <= PLL_RESET;
          rst_cnt   <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = st;
  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.fault     = fault_q;
  assign bus.lol_count = lol_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued when
// stimulus is applied and retired against measured DUT behaviour.
module tb_pll_lock_supervisor;
  logic refclk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t exp_q[$];

  pll_lock_supervisor_if bus();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT    (100),
    .LOCK_STABLE     (16),
    .MAX_RETRIES     (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus.master)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // 0:state 1:sys_rst 2:pll_rst 3:fault 4:lol_count
  function automatic int cur(input int sel);
    case (sel)
      0: return int'(bus.state);
      1: return int'(bus.sys_rst);
      2: return int'(bus.pll_rst);
      3: return int'(bus.fault);
      default: return int'(bus.lol_count);
    endcase
  endfunction

  // Counts rising edges until the selected output equals val; -1 on budget expiry.
  task automatic cnt_until(input int sel, input int val, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge refclk);
      #1;
      if (cur(sel) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic snap_reset(input string pfx);
    sb_push({pfx, "_state"}, 0);
    sb_push({pfx, "_pll_rst"}, 1);
    sb_push({pfx, "_sys_rst"}, 1);
    sb_push({pfx, "_fault"}, 0);
    sb_push({pfx, "_lol"}, 0);
    sb_pop(cur(0)); sb_pop(cur(2)); sb_pop(cur(1)); sb_pop(cur(3)); sb_pop(cur(4));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.locked = 1'b0;
    bus.retry_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    snap_reset("rst");

    // Nominal lock
    @(negedge refclk);
    rst = 1'b0;
    sb_push("nom_pll_pulse", 4);
    cnt_until(2, 0, 20, n);
    sb_pop(n);
    sb_push("nom_wait_state", 1);
    sb_pop(cur(0));
    repeat (16) @(posedge refclk);
    @(negedge refclk);
    sb_push("nom_lock_to_release", 19);
    bus.locked = 1'b1;
    cnt_until(1, 0, 60, n);
    sb_pop(n);
    sb_push("nom_run_state", 3);
    sb_push("nom_run_pll_rst", 0);
    sb_pop(cur(0));
    sb_pop(cur(2));

    // retry_req has no effect outside FAULT
    @(negedge refclk);
    bus.retry_req = 1'b1;
    @(negedge refclk);
    bus.retry_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    sb_push("run_retry_ignored_state", 3);
    sb_push("run_retry_ignored_sys_rst", 0);
    sb_pop(cur(0));
    sb_pop(cur(1));

    // Loss of lock, repeated past the lol_count saturation point
    for (int i = 0; i < 300; i++) begin
      @(negedge refclk);
      sb_push("lol_sys_rst_edges", 3);
      bus.locked = 1'b0;
      cnt_until(1, 1, 20, n);
      sb_pop(n);
      if (i == 0) begin
        sb_push("lol_pll_rst", 1);
        sb_push("lol_state", 0);
        sb_push("lol_count_first", 1);
        sb_pop(cur(2)); sb_pop(cur(0)); sb_pop(cur(4));
      end
      @(negedge refclk);
      sb_push("lol_relock_edges", 21);
      bus.locked = 1'b1;
      cnt_until(0, 3, 60, n);
      sb_pop(n);
    end
    sb_push("lol_count_sat", 255);
    sb_pop(cur(4));

    // Glitch during STABILIZE
    @(negedge refclk);
    sb_push("gl_lol_edges", 3);
    bus.locked = 1'b0;
    cnt_until(1, 1, 20, n);
    sb_pop(n);
    sb_push("gl_lol_count_held", 255);
    sb_pop(cur(4));
    @(negedge refclk);
    sb_push("gl_to_stabilize", 5);
    bus.locked = 1'b1;
    cnt_until(0, 2, 30, n);
    sb_pop(n);
    repeat (8) @(posedge refclk);
    @(negedge refclk);
    sb_push("gl_back_to_wait", 3);
    bus.locked = 1'b0;
    @(posedge refclk);
    #1;
    @(negedge refclk);
    bus.locked = 1'b1;
    cnt_until(0, 1, 20, n);
    sb_pop(n < 0 ? n : n + 1);
    sb_push("gl_sys_rst_held", 1);
    sb_pop(cur(1));
    sb_push("gl_restart_to_run", 17);
    cnt_until(0, 3, 40, n);
    sb_pop(n);

    // Async reset between edges while in STABILIZE
    @(negedge refclk);
    bus.locked = 1'b0;
    cnt_until(1, 1, 20, n);
    @(negedge refclk);
    bus.locked = 1'b1;
    sb_push("ar_to_stabilize", 5);
    cnt_until(0, 2, 30, n);
    sb_pop(n);
    repeat (4) @(posedge refclk);
    #3;
    rst = 1'b1;
    #1;
    snap_reset("async");
    bus.locked = 1'b0;
    repeat (2) @(posedge refclk);

    // Timeouts into FAULT
    @(negedge refclk);
    rst = 1'b0;
    sb_push("to_pulse1", 4);
    sb_push("to_wait1", 100);
    sb_push("to_pulse2", 4);
    sb_push("to_wait2", 100);
    cnt_until(2, 0, 20, n);  sb_pop(n);
    cnt_until(2, 1, 200, n); sb_pop(n);
    cnt_until(2, 0, 20, n);  sb_pop(n);
    cnt_until(0, 4, 200, n); sb_pop(n);
    sb_push("to_fault", 1);
    sb_push("to_fault_pll_rst", 1);
    sb_push("to_fault_sys_rst", 1);
    sb_pop(cur(3)); sb_pop(cur(2)); sb_pop(cur(1));
    repeat (10) @(posedge refclk);
    #1;
    sb_push("fault_sticky", 4);
    sb_pop(cur(0));

    // Recovery from FAULT
    @(negedge refclk);
    sb_push("rec_to_pll_reset", 1);
    bus.retry_req = 1'b1;
    cnt_until(0, 0, 5, n);
    sb_pop(n);
    sb_push("rec_fault_clear", 0);
    sb_pop(cur(3));
    @(negedge refclk);
    bus.retry_req = 1'b0;
    sb_push("rec_release_edges", 21);
    bus.locked = 1'b1;
    cnt_until(1, 0, 60, n);
    sb_pop(n);
    sb_push("rec_run_state", 3);
    sb_pop(cur(0));

    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
